// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data request paths.
// Data requests win unless the data streak has reached MAX_DSTREAK with an instruction waiting.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic        dreq;
  logic        tmo_hit;
  logic        ram_ok;
  logic        ram_bad;

  assign dreq    = dREN | dWEN;
  assign tmo_hit = (tmo_reg == TMO_LAST);
  assign ram_ok  = (ramstate == RAM_ACCESS);
  assign ram_bad = (ramstate == RAM_ERROR) || tmo_hit;

  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    tmo_next    = tmo_reg;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = 32'd0;
    dload       = 32'd0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;
    memerr      = 1'b0;

    case (state_reg)
      IDLE: begin
        tmo_next = 8'd0;
        if (dreq && !(iREN && streak_reg == STREAK_MAX))
          state_next = DGRANT;
        else if (iREN)
          state_next = IGRANT;
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        tmo_next = tmo_reg + 8'd1;
        if (!dreq) begin
          state_next = IDLE;
        end else if (ram_ok || ram_bad) begin
          dwait      = 1'b0;
          dload      = ram_ok ? ramload : ERR_WORD;
          memerr     = ~ram_ok;
          state_next = IDLE;
          // Streak only counts data grants that an instruction fetch had to wait through.
          if (!iREN)
            streak_next = 4'd0;
          else if (streak_reg < STREAK_MAX)
            streak_next = streak_reg + 4'd1;
        end
      end

      IGRANT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
        tmo_next = tmo_reg + 8'd1;
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_ok || ram_bad) begin
          iwait       = 1'b0;
          iload       = ram_ok ? ramload : ERR_WORD;
          memerr      = ~ram_ok;
          state_next  = IDLE;
          streak_next = 4'd0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      streak_reg <= 4'd0;
      tmo_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      tmo_reg    <= tmo_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected acknowledges into a queue,
// a negedge monitor pops and compares whenever iwait or dwait goes low.
module tb_mem_arbiter;

  localparam int MAXD = 4;
  localparam int TMO  = 64;
  localparam logic [31:0] KEY = 32'h5A5A0000;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  logic        use_fixed;
  logic [31:0] fixed_load;
  logic        mon_en;

  typedef struct {
    logic        port;   // 0 = instruction, 1 = data
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  // RAM data model: either a fixed word or an address-derived pattern.
  always_comb ramload = use_fixed ? fixed_load : (ramaddr ^ KEY);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic port, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic edge_drive();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare every acknowledge against the scoreboard.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!iwait && !dwait) begin
        check("both_wait_low", 1, 0);
      end else if (!iwait || !dwait) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {31'd0, ~dwait}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_port", {31'd0, ~dwait}, {31'd0, e.port});
          check("ack_load", e.port ? dload : iload, e.data);
          check("ack_memerr", {31'd0, memerr}, {31'd0, e.err});
          $display("ack port=%s load=%h memerr=%0b", e.port ? "D" : "I",
                   e.port ? dload : iload, memerr);
        end
      end else begin
        if (memerr) check("stray_memerr", 1, 0);
        if (iload !== 32'd0 || dload !== 32'd0) check("load_zero_when_waiting", iload | dload, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    mon_en = 1'b0;
    use_fixed = 1'b1; fixed_load = 32'd0;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramstate = 2'd2;

    // Reset with every request asserted
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_memerr", memerr, 0);
    check("rst_ramaddr", ramaddr, 0);
    edge_drive();
    iREN = 0; dREN = 0; dWEN = 0; nRST = 1'b1;
    mon_en = 1'b1;
    edge_drive();

    // Single instruction read, immediate ACCESS
    iREN = 1; iaddr = 32'h40; ramstate = 2'd2; fixed_load = 32'h8C010004;
    push(1'b0, 32'h8C010004, 1'b0);
    @(negedge CLK);
    check("rd_idle_iwait", iwait, 1);
    @(negedge CLK);
    check("rd_ramREN", ramREN, 1);
    check("rd_ramaddr", ramaddr, 32'h40);
    check("rd_iwait", iwait, 0);
    edge_drive();
    iREN = 0;
    @(negedge CLK);
    check("rd_back_idle", ramREN, 0);

    // Data write with three BUSY cycles
    edge_drive();
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1; fixed_load = 32'd0;
    push(1'b1, 32'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      edge_drive();
      @(negedge CLK);
      check("wr_busy_dwait", dwait, 1);
      check("wr_ramWEN", ramWEN, 1);
      check("wr_ramaddr", ramaddr, 32'h100);
      check("wr_ramstore", ramstore, 32'hDEADBEEF);
    end
    edge_drive();
    ramstate = 2'd2;
    @(negedge CLK);
    check("wr_ack_dwait", dwait, 0);
    check("wr_ack_ramWEN", ramWEN, 1);
    edge_drive();
    dWEN = 0;
    @(negedge CLK);
    check("wr_after_dwait", dwait, 1);
    check("wr_after_ramstore", ramstore, 0);

    // Starvation bound: D x4 then I, twice
    edge_drive();
    use_fixed = 1'b0;
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300; ramstate = 2'd2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAXD; k++) push(1'b1, 32'h300 ^ KEY, 1'b0);
      push(1'b0, 32'h200 ^ KEY, 1'b0);
    end
    repeat (20) @(posedge CLK);
    #1;
    iREN = 0; dREN = 0;
    check("starve_drained", exp_q.size(), 0);

    // ERROR reported by the RAM on the grant cycle
    edge_drive();
    dREN = 1; daddr = 32'h400; ramstate = 2'd3;
    push(1'b1, BAD, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    check("err_memerr", memerr, 1);
    edge_drive();
    dREN = 0;

    // Timeout while RAM stays BUSY
    edge_drive();
    dREN = 1; daddr = 32'h500; ramstate = 2'd1;
    push(1'b1, BAD, 1'b1);
    early = 1'b0;
    for (int k = 1; k < TMO; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!dwait) early = 1'b1;
    end
    check("tmo_not_early", early, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("tmo_ack_dwait", dwait, 0);
    check("tmo_ack_dload", dload, BAD);
    edge_drive();
    dREN = 0;

    // Requester abort while BUSY
    edge_drive();
    dREN = 1; daddr = 32'h600; ramstate = 2'd1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_ramREN_granted", ramREN, 1);
    edge_drive();
    dREN = 0;
    @(negedge CLK);
    check("abort_ramREN_drop", ramREN, 0);
    check("abort_dwait", dwait, 1);
    @(posedge CLK);
    @(negedge CLK);
    check("abort_idle_ramaddr", ramaddr, 0);

    // Reset during an instruction grant
    edge_drive();
    iREN = 1; iaddr = 32'h700; ramstate = 2'd1;
    @(posedge CLK);
    @(negedge CLK);
    check("rstmid_granted", ramREN, 1);
    edge_drive();
    nRST = 1'b0;
    @(negedge CLK);
    check("rstmid_still_granted", ramaddr, 32'h700);
    edge_drive();
    check("rstmid_iwait", iwait, 1);
    check("rstmid_ramREN", ramREN, 0);
    iREN = 0; nRST = 1'b1;
    repeat (3) edge_drive();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
